// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter between ALU and load writeback, with a pending-register scoreboard.
// Optional macro R0_DISCARD_EN: writes and claims to register 0 are dropped.
module regfile_write_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_req,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    output logic        alu_gnt,
    input  logic        mem_req,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    output logic        mem_gnt,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic        claim_valid,
    input  logic [4:0]  claim_addr,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        rs_pending,
    output logic        rt_pending,
    output logic [5:0]  pending_count
);

    logic        prio_q, prio_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic [31:0] pend_q, pend_d;
    logic [5:0]  count_q, count_d;

    logic        alu_gnt_c, mem_gnt_c;
    logic        alu_acc, mem_acc, xfer;
    logic [4:0]  xfer_addr;
    logic [31:0] xfer_data;
    logic        wr_en, claim_en;

    // Grants are masked by reset so nothing can be accepted while it is held.
    always_comb begin
        alu_gnt_c = 1'b0;
        mem_gnt_c = 1'b0;
        if (!reset) begin
            if (alu_req && (!mem_req || !prio_q)) begin
                alu_gnt_c = 1'b1;
            end else if (mem_req) begin
                mem_gnt_c = 1'b1;
            end
        end
    end

    assign alu_acc   = alu_req && alu_gnt_c;
    assign mem_acc   = mem_req && mem_gnt_c;
    assign xfer      = alu_acc || mem_acc;
    assign xfer_addr = alu_acc ? alu_addr : mem_addr;
    assign xfer_data = alu_acc ? alu_data : mem_data;

`ifdef R0_DISCARD_EN
    assign wr_en    = xfer && (xfer_addr != 5'd0);
    assign claim_en = claim_valid && (claim_addr != 5'd0);
`else
    assign wr_en    = xfer;
    assign claim_en = claim_valid;
`endif

    always_comb begin
        prio_d     = prio_q;
        rf_we_d    = wr_en;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (alu_acc) begin
            prio_d = 1'b1;
        end else if (mem_acc) begin
            prio_d = 1'b0;
        end
        if (wr_en) begin
            rf_waddr_d = xfer_addr;
            rf_wdata_d = xfer_data;
        end
    end

    // Clear first, then claim, so a claim to the same address wins.
    always_comb begin
        pend_d = pend_q;
        if (xfer) begin
            pend_d[xfer_addr] = 1'b0;
        end
        if (claim_en) begin
            pend_d[claim_addr] = 1'b1;
        end
    end

    always_comb begin
        count_d = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            count_d = count_d + {5'b0, pend_d[i]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio_q     <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pend_q     <= '0;
            count_q    <= '0;
        end else begin
            prio_q     <= prio_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            pend_q     <= pend_d;
            count_q    <= count_d;
        end
    end

    assign alu_gnt       = alu_gnt_c;
    assign mem_gnt       = mem_gnt_c;
    assign rf_we         = rf_we_q;
    assign rf_waddr      = rf_waddr_q;
    assign rf_wdata      = rf_wdata_q;
    assign rs_pending    = pend_q[rs_addr];
    assign rt_pending    = pend_q[rt_addr];
    assign pending_count = count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: arbitration order, write latency, scoreboard and async reset.
module tb_regfile_write_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_req, mem_req, claim_valid;
    logic [4:0]  alu_addr, mem_addr, claim_addr, rs_addr, rt_addr;
    logic [31:0] alu_data, mem_data;
    logic        alu_gnt, mem_gnt, rf_we, rs_pending, rt_pending;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [5:0]  pending_count;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter dut (
        .clock(clock), .reset(reset),
        .alu_req(alu_req), .alu_addr(alu_addr), .alu_data(alu_data), .alu_gnt(alu_gnt),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_gnt(mem_gnt),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .claim_valid(claim_valid), .claim_addr(claim_addr),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_pending(rs_pending), .rt_pending(rt_pending),
        .pending_count(pending_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        alu_req = 1'b1; mem_req = 1'b1; claim_valid = 1'b0;
        alu_addr = 5'd1; alu_data = 32'hA1A1_A1A1;
        mem_addr = 5'd2; mem_data = 32'hB2B2_B2B2;
        claim_addr = '0; rs_addr = '0; rt_addr = '0;
        #2;
        check("rst_we", rf_we, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_count", pending_count, 0);
        check("rst_alu_gnt", alu_gnt, 0);
        check("rst_mem_gnt", mem_gnt, 0);
        tick();
        check("rst_no_accept", rf_we, 0);
        reset = 1'b0;
        #1;

        // Both requesting: ALU, MEM, ALU, MEM
        check("rr0_alu_gnt", alu_gnt, 1);
        check("rr0_mem_gnt", mem_gnt, 0);
        tick();
        check("rr1_we", rf_we, 1);
        check("rr1_waddr", rf_waddr, 1);
        check("rr1_wdata", rf_wdata, 32'hA1A1_A1A1);
        check("rr1_mem_gnt", mem_gnt, 1);
        check("rr1_alu_gnt", alu_gnt, 0);
        alu_addr = 5'd3; alu_data = 32'hC3C3_C3C3;
        tick();
        check("rr2_we", rf_we, 1);
        check("rr2_waddr", rf_waddr, 2);
        check("rr2_wdata", rf_wdata, 32'hB2B2_B2B2);
        check("rr2_alu_gnt", alu_gnt, 1);
        mem_addr = 5'd4; mem_data = 32'hD4D4_D4D4;
        tick();
        check("rr3_we", rf_we, 1);
        check("rr3_waddr", rf_waddr, 3);
        check("rr3_mem_gnt", mem_gnt, 1);
        tick();
        check("rr4_we", rf_we, 1);
        check("rr4_waddr", rf_waddr, 4);
        check("rr4_wdata", rf_wdata, 32'hD4D4_D4D4);
        alu_req = 1'b0; mem_req = 1'b0;
        tick();
        check("idle_we", rf_we, 0);
        check("idle_waddr_hold", rf_waddr, 4);
        check("idle_wdata_hold", rf_wdata, 32'hD4D4_D4D4);

        // Lone requesters are granted regardless of prio
        alu_req = 1'b1; alu_addr = 5'd10; alu_data = 32'h0000_0010;
        #1;
        check("solo_alu_gnt", alu_gnt, 1);
        tick();
        mem_req = 1'b0;
        #1;
        check("solo_alu_again_gnt", alu_gnt, 1);
        alu_req = 1'b0;
        mem_req = 1'b1; mem_addr = 5'd11; mem_data = 32'h0000_0011;
        #1;
        check("solo_mem_gnt", mem_gnt, 1);
        check("solo_mem_alu_gnt", alu_gnt, 0);
        tick();
        check("solo_mem_waddr", rf_waddr, 11);
        mem_req = 1'b0;
        // prio now points to ALU after the MEM transfer
        alu_req = 1'b1; mem_req = 1'b1;
        #1;
        check("prio_after_mem", alu_gnt, 1);
        alu_req = 1'b0; mem_req = 1'b0;
        tick();

        // Claim 5, clear it with an ALU write three cycles later
        rs_addr = 5'd5; claim_valid = 1'b1; claim_addr = 5'd5;
        #1;
        check("c5_before", rs_pending, 0);
        tick();
        claim_valid = 1'b0;
        check("c5_cyc1", rs_pending, 1);
        check("c5_cnt1", pending_count, 1);
        tick();
        check("c5_cyc2", rs_pending, 1);
        tick();
        check("c5_cyc3", rs_pending, 1);
        alu_req = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEAD_BEEF;
        #1;
        check("c5_alu_gnt", alu_gnt, 1);
        tick();
        alu_req = 1'b0;
        check("c5_cyc4", rs_pending, 0);
        check("c5_cnt0", pending_count, 0);
        check("c5_we", rf_we, 1);
        check("c5_waddr", rf_waddr, 5);
        check("c5_wdata", rf_wdata, 32'hDEAD_BEEF);

        // Claim and MEM clear of 7 at the same edge: claim wins
        rt_addr = 5'd7;
        claim_valid = 1'b1; claim_addr = 5'd7;
        mem_req = 1'b1; mem_addr = 5'd7; mem_data = 32'h7777_7777;
        tick();
        mem_req = 1'b0;
        check("c7_pending", rt_pending, 1);
        check("c7_cnt", pending_count, 1);
        tick();
        check("c7_reclaim_cnt", pending_count, 1);
        claim_addr = 5'd9;
        tick();
        claim_valid = 1'b0;
        check("c9_cnt", pending_count, 2);
        alu_req = 1'b1; alu_addr = 5'd12; alu_data = 32'h1212_1212;
        tick();
        alu_req = 1'b0;
        check("clr_nonpend_cnt", pending_count, 2);
        check("clr_nonpend_we", rf_we, 1);
        mem_req = 1'b1; mem_addr = 5'd7;
        tick();
        mem_req = 1'b0;
        check("c7_clear_cnt", pending_count, 1);
        check("c7_clear_pend", rt_pending, 0);

        // Claim every register
        claim_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            claim_addr = 5'(i);
            tick();
        end
        claim_valid = 1'b0;
`ifdef R0_DISCARD_EN
        check("all_cnt", pending_count, 31);
`else
        check("all_cnt", pending_count, 32);
`endif

        // Async reset mid-write
        alu_req = 1'b1; alu_addr = 5'd3; alu_data = 32'h3333_3333;
        tick();
        mem_req = 1'b1;
        check("pre_rst_we", rf_we, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_cnt", pending_count, 0);
        check("mid_rst_alu_gnt", alu_gnt, 0);
        check("mid_rst_mem_gnt", mem_gnt, 0);
        check("mid_rst_waddr", rf_waddr, 0);
        rs_addr = 5'd9;
        #1;
        check("mid_rst_pend9", rs_pending, 0);
        reset = 1'b0;
        #1;
        check("post_rst_prio", alu_gnt, 1);
        alu_req = 1'b0; mem_req = 1'b0;
        tick();
        check("post_rst_we", rf_we, 0);

        // Register 0 handling
        alu_req = 1'b1; alu_addr = 5'd0; alu_data = 32'h0000_0001;
        #1;
        check("r0_alu_gnt", alu_gnt, 1);
        tick();
        alu_req = 1'b0;
        rs_addr = 5'd0;
        claim_valid = 1'b1; claim_addr = 5'd0;
`ifdef R0_DISCARD_EN
        check("r0_we", rf_we, 0);
`else
        check("r0_we", rf_we, 1);
        check("r0_waddr", rf_waddr, 0);
        check("r0_wdata", rf_wdata, 1);
`endif
        tick();
        claim_valid = 1'b0;
`ifdef R0_DISCARD_EN
        check("r0_pending", rs_pending, 0);
`else
        check("r0_pending", rs_pending, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 clock  in  1  single clock; all state updates on posedge clock.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 alu_req, alu_addr, alu_data  in  1/5/32  ALU writeback request: valid, destination register, data.
REQ-004 alu_gnt  out  1  combinational grant; alu_req and alu_gnt high at the same posedge = ALU write accepted.
REQ-005 mem_req, mem_addr, mem_data  in  1/5/32  load writeback request: valid, destination register, data.
REQ-006 mem_gnt  out  1  combinational grant; mem_req and mem_gnt high at the same posedge = MEM write accepted.
REQ-007 rf_we, rf_waddr, rf_wdata  out  1/5/32  registered drive to the register file write port (WriteEnable, write_address, data_in).
REQ-008 claim_valid, claim_addr  in  1/5  issue stage marks a destination register pending.
REQ-009 rs_addr, rt_addr  in  5/5  hazard query addresses.
REQ-010 rs_pending, rt_pending  out  1/1  combinational: pending bit of rs_addr / rt_addr.
REQ-011 pending_count  out  6  registered population count of the pending bits (0..32).

Function
REQ-012 At most one of alu_gnt and mem_gnt shall be high in any cycle.
- A grant is never high without the matching req.
REQ-013 Arbitration shall be round-robin using a 1-bit pointer prio (0 = ALU preferred, 1 = MEM preferred).
- Only one requester active: that requester is granted, regardless of prio.
REQ-014 After any accepted transfer, prio shall point to the requester that was not granted.
REQ-015 A requester not granted shall hold req, addr and data stable until granted.
- This is a requester obligation; the arbiter does not check it.
REQ-016 Write latency: an accepted transfer at edge N shall produce rf_we=1, rf_waddr=addr and rf_wdata=data for exactly the cycle following edge N.
- With no transfer, rf_we=0 the next cycle.
- rf_waddr and rf_wdata hold their previous values.
REQ-017 Back-to-back transfers shall sustain one write per cycle; with both requesting continuously, grants alternate ALU, MEM, ALU, ...
REQ-018 Scoreboard: 32 pending bits.
- At a posedge, claim_valid=1 sets pending[claim_addr].
- At the same posedge, an accepted transfer clears pending[addr].
REQ-019 Claim and clear of the same address at the same edge: claim wins, and the bit ends set.
REQ-020 Claim of an already-pending address: the bit stays set, with no error.
- Clear of a non-pending address: no effect.
REQ-021 pending_count shall equal the number of set pending bits after each edge, saturating range 0..32.

Reset
REQ-022 While reset is high, all outputs and state shall take their reset values immediately, without waiting for a clock edge:
- rf_we=0, rf_waddr=0, rf_wdata=0.
- prio=0.
- All pending bits 0, pending_count=0.
REQ-023 While reset is high, alu_gnt=0 and mem_gnt=0, and no transfer is accepted.
REQ-024 Reset asserted mid-operation shall discard the in-flight write.
- rf_we falls to 0 immediately.
- All claims are lost.

Configuration
REQ-025 Macro R0_DISCARD_EN.
- Defined: a transfer with addr=0 is granted and accepted normally, but rf_we stays 0 for it.
- Defined: a claim to address 0 is ignored, and rs_pending/rt_pending for address 0 read 0.
- Undefined: address 0 is treated like any other register.

Verification
REQ-026 After reset, alu_req=1 and mem_req=1 both held for 4 cycles -> grant order ALU, MEM, ALU, MEM; rf_waddr follows one cycle later; rf_we=1 for 4 consecutive cycles.
REQ-027 claim_addr=5 at cycle 0, then ALU writes addr 5 with data 0xDEADBEEF at cycle 3 -> rs_addr=5 reads rs_pending=1 in cycles 1-3 and 0 from cycle 4; pending_count goes 1 then 0; rf_wdata=0xDEADBEEF in cycle 4.
REQ-028 Claim to addr 7 and an accepted MEM write to addr 7 at the same edge -> pending[7]=1 and pending_count=1 afterwards.
REQ-029 Reset asserted between clock edges while rf_we=1 -> rf_we=0, pending_count=0 and both grants 0 before the next edge.
REQ-030 With R0_DISCARD_EN defined, ALU write to addr 0 with data 0x1 -> alu_gnt=1, and rf_we stays 0 the next cycle; undefined -> rf_we=1, rf_waddr=0.
